// File: rtl/psum_ofifo_pkg.sv
// Default geometry for the psum output collector.
// The core top level normally overrides these through parameters.
package psum_ofifo_pkg;
   localparam int unsigned COL_DEF     = 8;
   localparam int unsigned BW_PSUM_DEF = 22;
   localparam int unsigned DEPTH_DEF   = 16;
endpackage

// File: rtl/psum_ofifo_if.sv
// Psum write bus, row read handshake and status flags of the output collector.
interface psum_ofifo_if
   import psum_ofifo_pkg::*;
#(
   parameter int unsigned col     = COL_DEF,
   parameter int unsigned bw_psum = BW_PSUM_DEF
);
   logic [col*bw_psum-1:0] in;
   logic [col-1:0]         wr;
   logic                   rd;
   logic                   o_valid;
   logic                   o_full;
   logic                   o_empty;
   logic [col*bw_psum-1:0] out;
   logic                   out_vld;
   logic                   o_overflow;
   logic                   o_underflow;

   // master: MAC array plus downstream reader; slave: the collector
   modport master (
      output in, wr, rd,
      input  o_valid, o_full, o_empty, out, out_vld, o_overflow, o_underflow
   );
   modport slave (
      input  in, wr, rd,
      output o_valid, o_full, o_empty, out, out_vld, o_overflow, o_underflow
   );
endinterface

// File: rtl/psum_ofifo_fifo_lane.sv
// Single-lane circular buffer with extended pointers; exposes full/empty/head.
// A write into a full lane is accepted only when the same cycle pops.
module fifo_lane #(
   parameter int unsigned depth = 16,
   parameter int unsigned bw    = 22
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr,
   input  logic          pop,
   input  logic [bw-1:0] din,
   output logic          full_c,
   output logic          empty_c,
   output logic          drop_c,
   output logic [bw-1:0] head_c
);
   localparam int unsigned ptr_w = $clog2(depth);
   localparam logic [ptr_w:0] ptr_one = (ptr_w+1)'(1);

   logic [ptr_w:0] wptr;
   logic [ptr_w:0] rptr;
   logic [bw-1:0]  mem [depth];
   logic           wr_en;

   assign empty_c = (wptr == rptr);
   assign full_c  = (wptr[ptr_w-1:0] == rptr[ptr_w-1:0]) && (wptr[ptr_w] != rptr[ptr_w]);
   assign wr_en   = wr && (!full_c || pop);
   assign drop_c  = wr && full_c && !pop;
   assign head_c  = mem[rptr[ptr_w-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_en) wptr <= wptr + ptr_one;
         if (pop)   rptr <= rptr + ptr_one;
      end
   end

   // storage needs no reset; the pointers define what is live
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr[ptr_w-1:0]] <= din;
   end
endmodule

// File: rtl/psum_ofifo.sv
// Output-side psum collector: buffers skewed per-column writes per lane and
// pops them as aligned rows once every lane has data.
module psum_ofifo
   import psum_ofifo_pkg::*;
#(
   parameter int unsigned col     = COL_DEF,
   parameter int unsigned bw_psum = BW_PSUM_DEF,
   parameter int unsigned depth   = DEPTH_DEF
) (
   input logic         clk,
   input logic         reset,
   psum_ofifo_if.slave bus
);
   logic [col-1:0]         full_c;
   logic [col-1:0]         empty_c;
   logic [col-1:0]         drop_c;
   logic [col*bw_psum-1:0] head_row_c;
   logic                   pop_c;
   logic                   valid_c;

   logic [col*bw_psum-1:0] out_q;
   logic                   out_vld_q;
   logic                   overflow_q;
   logic                   underflow_q;

   for (genvar i = 0; i < int'(col); i++) begin : g_lane
      fifo_lane #(
         .depth (depth),
         .bw    (bw_psum)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .wr      (bus.wr[i]),
         .pop     (pop_c),
         .din     (bus.in[i*bw_psum +: bw_psum]),
         .full_c  (full_c[i]),
         .empty_c (empty_c[i]),
         .drop_c  (drop_c[i]),
         .head_c  (head_row_c[i*bw_psum +: bw_psum])
      );
   end

   // status depends on registered pointers only
   assign valid_c = ~|empty_c;
   assign pop_c   = bus.rd && valid_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q       <= '0;
         out_vld_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         out_vld_q <= pop_c;
         if (pop_c) out_q <= head_row_c;
         if (|drop_c) overflow_q <= 1'b1;
         if (bus.rd && !valid_c) underflow_q <= 1'b1;
      end
   end

   assign bus.o_valid     = valid_c;
   assign bus.o_full      = |full_c;
   assign bus.o_empty     = &empty_c;
   assign bus.out         = out_q;
   assign bus.out_vld     = out_vld_q;
   assign bus.o_overflow  = overflow_q;
   assign bus.o_underflow = underflow_q;
endmodule
